le_config_loader: RTL and testbench
===================================

// Module: le_config_loader
// PURPOSE
//  Serial configuration writer for the logic-element grid. Receives a framed bitstream
//  (sync byte, NUM_LE config words, XOR checksum) from the genetic-search host and
//  assembles it in a shadow bank. On a good checksum, commits the bank atomically to the
//  flat config bus that drives every LE.
//  Per-LE word layout (CFG_W=32):
//    [15:0]  lut
//    [23:16] lutIns (lutIns[k] at [17+2k:16+2k])
//    [25:24] north output conf, [27:26] east, [29:28] west, [31:30] south
// PARAMETERS
//  NUM_LE  16     number of logic elements configured per frame (>=1)
//  CFG_W   32     config bits per LE; fixed at 32, a multiple of 8
//  SYNC    8'hA5  frame sync byte
// PORTS
//  clk         in   1             single clock, all logic rising-edge
//  reset       in   1             asynchronous, active-high
//  serialIn    in   1             serial config data bit
//  serialValid in   1             serialIn is sampled on a clk edge only when this is 1
//  abort       in   1             sync abort: drop current frame, back to HUNT
//  cfgOut      out  NUM_LE*CFG_W  active config; LE i occupies [i*CFG_W +: CFG_W]
//  cfgUpdate   out  1             1-cycle pulse when cfgOut takes a new frame
//  cfgError    out  1             1-cycle pulse on checksum mismatch
//  busy        out  1             high while a frame is being received (LOAD or CHECK)
// BEHAVIOUR
//  Reset (async assert) clears everything:
//   - cfgOut, shadow bank, counters and checksum go to 0
//   - cfgUpdate, cfgError and busy go to 0; state goes to HUNT
//   - reset mid-frame discards the frame; no partial commit, ever
//  HUNT:
//   - each valid bit shifts into an 8-bit sync register (new bit enters at the LSB)
//   - when the register equals SYNC after a shift, go to LOAD; bit counter = 0, checksum = 0
//   - the sync register clears on entry to HUNT
//  LOAD:
//   - each valid bit shifts into the shadow bank: LE0 first, MSB of each word first
//   - byte accumulator: XOR each completed payload byte into the checksum
//   - after NUM_LE*CFG_W valid bits, go to CHECK
//  CHECK:
//   - collect 8 valid bits, MSB first
//   - on the 8th bit, compare against the running checksum
//   - match: next edge loads cfgOut <= shadow and pulses cfgUpdate for 1 cycle
//   - mismatch: next edge pulses cfgError for 1 cycle; cfgOut is unchanged
//   - either way, return to HUNT on that same edge
//  Cycles with serialValid=0 change no state; bit gaps of any length are legal.
//  abort=1 while in LOAD or CHECK: next state is HUNT, shadow contents are don't-care, no pulses.
//   - abort overrides a simultaneous serialValid, including on the final checksum bit
//   - abort in HUNT clears the sync register
//  busy = (state==LOAD || state==CHECK), registered with the state.
//  The sync pattern is not searched for inside LOAD/CHECK; payload bytes equal to SYNC are data.
//  cfgOut holds its value indefinitely between commits; LEs read it combinationally.
// TESTING (NUM_LE=2)
//  1. Good frame: A5, 0000FFFF, 12345678, chk 08 -> cfgUpdate 1 cycle after last bit;
//     cfgOut = 64'h12345678_0000FFFF.
//  2. Same frame with chk 09 -> cfgError pulses once; cfgOut keeps its prior value;
//     busy falls the same cycle.
//  3. Noise bits 1,0,1 then frame 1 with serialValid gapped randomly (1-5 idle cycles)
//     -> same result as test 1.
//  4. abort asserted after 20 payload bits, then a full good frame (LE0=FFFFFFFF,
//     LE1=0, chk 00) -> only the second frame commits.
//  5. reset asserted mid-LOAD (asynchronous, between clk edges) -> busy and cfgOut are 0
//     immediately; a following good frame commits normally.
//  6. Payload containing byte A5 (LE0=A5A5A5A5, LE1=0, chk 00) -> no resync;
//     cfgOut = 64'h00000000_A5A5A5A5.

Source files
------------

// File: rtl/le_config_loader.sv
// Serial configuration loader for the LE grid. It hunts for a sync byte, shifts a framed
// payload into a shadow bank, and commits the bank to cfgOut only if the XOR checksum matches.
module le_config_loader #(
  parameter int         NUM_LE = 16,
  parameter int         CFG_W  = 32,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serialIn,
  input  logic                    serialValid,
  input  logic                    abort,
  output logic [NUM_LE*CFG_W-1:0] cfgOut,
  output logic                    cfgUpdate,
  output logic                    cfgError,
  output logic                    busy
);

  localparam int TOTAL = NUM_LE * CFG_W;
  localparam int CNT_W = $clog2(TOTAL);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t             state, stateNext;
  logic [6:0]         syncReg;
  logic [6:0]         byteAcc;
  logic [6:0]         chkReg;
  logic [2:0]         chkCnt;
  logic [7:0]         checksum;
  logic [CNT_W-1:0]   bitCnt;
  logic [TOTAL-1:0]   shadow;

  logic               take;
  logic [7:0]         syncNext;
  logic [7:0]         byteNext;
  logic [7:0]         chkNext;
  logic               syncHit;
  logic               lastPayloadBit;
  logic               lastChkBit;
  logic [CNT_W-1:0]   shadowIdx;

  // abort wins over a simultaneous valid bit in every state.
  assign take           = serialValid && !abort;
  assign syncNext       = {syncReg, serialIn};
  assign byteNext       = {byteAcc, serialIn};
  assign chkNext        = {chkReg, serialIn};
  assign syncHit        = (syncNext == SYNC);
  assign lastPayloadBit = (bitCnt == CNT_W'(TOTAL - 1));
  assign lastChkBit     = (chkCnt == 3'd7);
  // Words arrive MSB first with LE0 first, so flipping the in-word offset bits maps the
  // stream position straight onto the flat bank index.
  assign shadowIdx      = bitCnt ^ CNT_W'(CFG_W - 1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    stateNext = state;
    case (state)
      HUNT:    if (take && syncHit) stateNext = LOAD;
      LOAD: begin
        if (abort)                          stateNext = HUNT;
        else if (take && lastPayloadBit)    stateNext = CHECK;
      end
      CHECK: begin
        if (abort)                          stateNext = HUNT;
        else if (take && lastChkBit)        stateNext = HUNT;
      end
      default:                              stateNext = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext == LOAD) || (stateNext == CHECK);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shadow bank is reset along with cfgOut so a reset mid-frame can never
      // leave stale data that a later commit would expose.
      shadow    <= '0;
      cfgOut    <= '0;
      cfgUpdate <= 1'b0;
      cfgError  <= 1'b0;
      syncReg   <= '0;
      byteAcc   <= '0;
      chkReg    <= '0;
      chkCnt    <= '0;
      checksum  <= '0;
      bitCnt    <= '0;
    end else begin
      cfgUpdate <= 1'b0;
      cfgError  <= 1'b0;
      case (state)
        HUNT: begin
          if (abort) begin
            syncReg <= '0;
          end else if (serialValid) begin
            if (syncHit) begin
              syncReg  <= '0;
              bitCnt   <= '0;
              checksum <= '0;
              chkCnt   <= '0;
            end else begin
              syncReg <= syncNext[6:0];
            end
          end
        end
        LOAD: begin
          if (take) begin
            shadow[shadowIdx] <= serialIn;
            bitCnt            <= bitCnt + CNT_W'(1);
            byteAcc           <= byteNext[6:0];
            if (bitCnt[2:0] == 3'd7) checksum <= checksum ^ byteNext;
            if (lastPayloadBit)      chkCnt   <= '0;
          end
        end
        CHECK: begin
          if (take) begin
            chkReg <= chkNext[6:0];
            chkCnt <= chkCnt + 3'd1;
            if (lastChkBit) begin
              if (chkNext == checksum) begin
                cfgOut    <= shadow;
                cfgUpdate <= 1'b1;
              end else begin
                cfgError  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_le_config_loader.sv
// Directed bench for le_config_loader with NUM_LE=2: good/bad frames, gapped bits,
// abort, asynchronous reset mid-frame and sync-valued payload bytes.
module tb_le_config_loader;

  localparam int NUM_LE = 2;
  localparam int CFG_W  = 32;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    serialIn = 1'b0;
  logic                    serialValid = 1'b0;
  logic                    abort = 1'b0;
  logic [NUM_LE*CFG_W-1:0] cfgOut;
  logic                    cfgUpdate;
  logic                    cfgError;
  logic                    busy;

  int tests = 0;
  int fails = 0;

  le_config_loader #(.NUM_LE(NUM_LE), .CFG_W(CFG_W), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn), .serialValid(serialValid),
    .abort(abort), .cfgOut(cfgOut), .cfgUpdate(cfgUpdate), .cfgError(cfgError), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one bit for one edge; returns #1 after the edge, where outputs are sampled.
  task automatic sendBit(input logic b, input logic ab, input bit gapped);
    if (gapped) begin
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
    end
    serialIn    = b;
    serialValid = 1'b1;
    abort       = ab;
    @(posedge clk);
    #1;
    serialValid = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] v, input bit gapped);
    for (int i = 7; i >= 0; i--) sendBit(v[i], 1'b0, gapped);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gapped);
    for (int i = 31; i >= 0; i--) sendBit(w[i], 1'b0, gapped);
  endtask

  task automatic sendFrame(input logic [31:0] le0, input logic [31:0] le1,
                           input logic [7:0] chk, input bit gapped);
    sendByte(8'hA5, gapped);
    sendWord(le0, gapped);
    sendWord(le1, gapped);
    sendByte(chk, gapped);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;

    // Reset state
    reset = 1'b1;
    #12;
    check("rst_cfgOut", cfgOut, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_update", {63'h0, cfgUpdate}, 64'h0);
    check("rst_error", {63'h0, cfgError}, 64'h0);
    reset = 1'b0;
    idle(2);

    // Test 1: good frame
    sendByte(8'hA5, 1'b0);
    check("t1_busy_load", {63'h0, busy}, 64'h1);
    sendWord(32'h0000FFFF, 1'b0);
    sendWord(32'h12345678, 1'b0);
    check("t1_busy_check", {63'h0, busy}, 64'h1);
    check("t1_no_early_commit", cfgOut, 64'h0);
    sendByte(8'h08, 1'b0);
    check("t1_update", {63'h0, cfgUpdate}, 64'h1);
    check("t1_error", {63'h0, cfgError}, 64'h0);
    check("t1_cfgOut", cfgOut, 64'h12345678_0000FFFF);
    check("t1_busy_done", {63'h0, busy}, 64'h0);
    idle(1);
    check("t1_update_1cyc", {63'h0, cfgUpdate}, 64'h0);

    // Test 2: bad checksum
    sendFrame(32'h0000FFFF, 32'h12345678, 8'h09, 1'b0);
    check("t2_error", {63'h0, cfgError}, 64'h1);
    check("t2_update", {63'h0, cfgUpdate}, 64'h0);
    check("t2_busy", {63'h0, busy}, 64'h0);
    check("t2_cfgOut_kept", cfgOut, 64'h12345678_0000FFFF);
    idle(1);
    check("t2_error_1cyc", {63'h0, cfgError}, 64'h0);

    // Test 3: noise then gapped good frame
    sendBit(1'b1, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    check("t3_noise_idle", {63'h0, busy}, 64'h0);
    sendFrame(32'h0000FFFF, 32'h12345678, 8'h08, 1'b1);
    check("t3_update", {63'h0, cfgUpdate}, 64'h1);
    check("t3_cfgOut", cfgOut, 64'h12345678_0000FFFF);

    // Test 4: abort after 20 payload bits, then a good frame
    sendByte(8'hA5, 1'b0);
    w = 32'hDEADBEEF;
    for (int i = 31; i >= 12; i--) sendBit(w[i], 1'b0, 1'b0);
    sendBit(1'b1, 1'b1, 1'b0);
    check("t4_abort_busy", {63'h0, busy}, 64'h0);
    idle(3);
    check("t4_abort_cfgOut", cfgOut, 64'h12345678_0000FFFF);
    sendFrame(32'hFFFFFFFF, 32'h00000000, 8'h00, 1'b0);
    check("t4_update", {63'h0, cfgUpdate}, 64'h1);
    check("t4_cfgOut", cfgOut, 64'h00000000_FFFFFFFF);

    // Abort on the final checksum bit overrides the valid bit
    sendByte(8'hA5, 1'b0);
    sendWord(32'h0000FFFF, 1'b0);
    sendWord(32'h12345678, 1'b0);
    for (int i = 7; i >= 1; i--) sendBit(1'(8'h08 >> i), 1'b0, 1'b0);
    sendBit(1'b0, 1'b1, 1'b0);
    check("t4b_no_update", {63'h0, cfgUpdate}, 64'h0);
    check("t4b_no_error", {63'h0, cfgError}, 64'h0);
    check("t4b_busy", {63'h0, busy}, 64'h0);
    check("t4b_cfgOut", cfgOut, 64'h00000000_FFFFFFFF);

    // Test 5: asynchronous reset mid-LOAD
    sendByte(8'hA5, 1'b0);
    sendWord(32'hCAFEF00D, 1'b0);
    check("t5_busy_before", {63'h0, busy}, 64'h1);
    #3;
    reset = 1'b1;
    #1;
    check("t5_busy_async", {63'h0, busy}, 64'h0);
    check("t5_cfgOut_async", cfgOut, 64'h0);
    #2;
    reset = 1'b0;
    sendFrame(32'h0000FFFF, 32'h12345678, 8'h08, 1'b0);
    check("t5_update", {63'h0, cfgUpdate}, 64'h1);
    check("t5_cfgOut", cfgOut, 64'h12345678_0000FFFF);

    // Test 6: payload bytes equal to SYNC are data
    sendFrame(32'hA5A5A5A5, 32'h00000000, 8'h00, 1'b0);
    check("t6_update", {63'h0, cfgUpdate}, 64'h1);
    check("t6_cfgOut", cfgOut, 64'h00000000_A5A5A5A5);
    idle(2);
    check("t6_idle_busy", {63'h0, busy}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
